// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// and data access. Data wins by default; a starvation counter hands the port to
// a waiting fetch after STARVE_MAX back-to-back data grants. A watchdog aborts
// any access the memory never acknowledges and raises a sticky bus error.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          IfReq,
    input  logic [AW-1:0] IfAddr,
    output logic [DW-1:0] IfRdata,
    output logic          IfValid,
    output logic          IfStall,
    input  logic          DmReq,
    input  logic          DmWe,
    input  logic [AW-1:0] DmAddr,
    input  logic [DW-1:0] DmWdata,
    output logic [DW-1:0] DmRdata,
    output logic          DmValid,
    output logic          DmStall,
    output logic          MemEn,
    output logic          MemWe,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWdata,
    input  logic [DW-1:0] MemRdata,
    input  logic          MemReady,
    output logic          BusErr
);

    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_DM_BUSY = 2'd2
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_starve;
    logic [TW-1:0]   r_tmo;
    logic            r_if_valid;
    logic            r_dm_valid;
    logic [DW-1:0]   r_if_rdata;
    logic [DW-1:0]   r_dm_rdata;
    logic            r_mem_en;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic            r_bus_err;

    state_t          w_state_nxt;
    logic [SW-1:0]   w_starve_nxt;
    logic [TW-1:0]   w_tmo_nxt;
    logic            w_if_valid_nxt;
    logic            w_dm_valid_nxt;
    logic [DW-1:0]   w_if_rdata_nxt;
    logic [DW-1:0]   w_dm_rdata_nxt;
    logic            w_mem_en_nxt;
    logic            w_mem_we_nxt;
    logic [AW-1:0]   w_mem_addr_nxt;
    logic [DW-1:0]   w_mem_wdata_nxt;
    logic            w_bus_err_nxt;

    // A requester whose completion pulse is showing this cycle must not be re-granted.
    logic w_if_elig;
    logic w_dm_elig;
    logic w_fetch_turn;

    assign w_if_elig    = IfReq & ~r_if_valid;
    assign w_dm_elig    = DmReq & ~r_dm_valid;
    assign w_fetch_turn = w_if_elig & (r_starve == SW'(STARVE_MAX));

    // Next-state, grant, starvation and watchdog decisions; every register holds by default.
    always_comb begin
        w_state_nxt     = r_state;
        w_starve_nxt    = r_starve;
        w_tmo_nxt       = r_tmo;
        w_if_valid_nxt  = 1'b0;
        w_dm_valid_nxt  = 1'b0;
        w_if_rdata_nxt  = r_if_rdata;
        w_dm_rdata_nxt  = r_dm_rdata;
        w_mem_en_nxt    = r_mem_en;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_bus_err_nxt   = r_bus_err;

        case (r_state)
            ST_IDLE: begin
                if (w_dm_elig && !w_fetch_turn) begin
                    w_state_nxt     = ST_DM_BUSY;
                    w_mem_en_nxt    = 1'b1;
                    w_mem_we_nxt    = DmWe;
                    w_mem_addr_nxt  = DmAddr;
                    w_mem_wdata_nxt = DmWdata;
                    w_tmo_nxt       = TW'(0);
                    // Count data wins only while a fetch is actually waiting.
                    if (w_if_elig && (r_starve != SW'(STARVE_MAX))) begin
                        w_starve_nxt = r_starve + SW'(1);
                    end else begin
                        w_starve_nxt = r_starve;
                    end
                end else if (w_if_elig) begin
                    w_state_nxt     = ST_IF_BUSY;
                    w_mem_en_nxt    = 1'b1;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = IfAddr;
                    w_mem_wdata_nxt = {DW{1'b0}};
                    w_tmo_nxt       = TW'(0);
                    w_starve_nxt    = SW'(0);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
                // No fetch pending means nobody is being starved.
                if (!IfReq) begin
                    w_starve_nxt = SW'(0);
                end else begin
                    w_starve_nxt = w_starve_nxt;
                end
            end
            ST_IF_BUSY, ST_DM_BUSY: begin
                if (MemReady) begin
                    // A ready in the same cycle as the watchdog limit still counts as success.
                    if (r_state == ST_IF_BUSY) begin
                        w_if_valid_nxt = 1'b1;
                        w_if_rdata_nxt = MemRdata;
                    end else begin
                        w_dm_valid_nxt = 1'b1;
                        w_dm_rdata_nxt = r_mem_we ? r_dm_rdata : MemRdata;
                    end
                    w_state_nxt  = ST_IDLE;
                    w_mem_en_nxt = 1'b0;
                    w_mem_we_nxt = 1'b0;
                end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                    // Abort: complete the requester with zero data and flag the bus.
                    if (r_state == ST_IF_BUSY) begin
                        w_if_valid_nxt = 1'b1;
                        w_if_rdata_nxt = {DW{1'b0}};
                    end else begin
                        w_dm_valid_nxt = 1'b1;
                        w_dm_rdata_nxt = {DW{1'b0}};
                    end
                    w_bus_err_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                    w_mem_en_nxt  = 1'b0;
                    w_mem_we_nxt  = 1'b0;
                end else begin
                    w_tmo_nxt = r_tmo + TW'(1);
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_mem_en_nxt = 1'b0;
                w_mem_we_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight without a pulse.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state     <= ST_IDLE;
            r_starve    <= SW'(0);
            r_tmo       <= TW'(0);
            r_if_valid  <= 1'b0;
            r_dm_valid  <= 1'b0;
            r_if_rdata  <= {DW{1'b0}};
            r_dm_rdata  <= {DW{1'b0}};
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {AW{1'b0}};
            r_mem_wdata <= {DW{1'b0}};
            r_bus_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_starve    <= w_starve_nxt;
            r_tmo       <= w_tmo_nxt;
            r_if_valid  <= w_if_valid_nxt;
            r_dm_valid  <= w_dm_valid_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_dm_rdata  <= w_dm_rdata_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_bus_err   <= w_bus_err_nxt;
        end
    end

    assign IfRdata  = r_if_rdata;
    assign IfValid  = r_if_valid;
    assign IfStall  = IfReq & ~r_if_valid;
    assign DmRdata  = r_dm_rdata;
    assign DmValid  = r_dm_valid;
    assign DmStall  = DmReq & ~r_dm_valid;
    assign MemEn    = r_mem_en;
    assign MemWe    = r_mem_we;
    assign MemAddr  = r_mem_addr;
    assign MemWdata = r_mem_wdata;
    assign BusErr   = r_bus_err;

endmodule
